serial_axil_regs: RTL and testbench

- AXI4-Lite responder (slave end) for the serial peripheral's control/data register bank.
- Accepts single-beat writes and reads from the AXI master (VIP or PS interconnect) and holds NUM_REGS 32-bit read/write registers.
- Exposes register contents and per-register write strobes to the serial core.
- Independent write and read channels; one outstanding transaction per direction.

---
 rtl/serial_axil_regs.sv | 226 ++++++++++++++++++++++
 tb/tb_serial_axil_regs.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_axil_regs.sv
// serial_axil_regs
// ----------------
// AXI4-Lite responder for the serial peripheral's control/data register
// bank. It holds NUM_REGS 32-bit read/write registers, accepts single-beat
// writes and reads (one outstanding transaction per direction) and exposes
// the register contents plus a per-register write pulse to the serial core.
//
// Ports:
//   S_AXI_ACLK, S_AXI_ARESET  clock, synchronous active-high reset
//   S_AXI_AW*                 write address channel (AWPROT ignored)
//   S_AXI_W*                  write data channel
//   S_AXI_B*                  write response channel (BRESP always OKAY)
//   S_AXI_AR*                 read address channel (ARPROT ignored)
//   S_AXI_R*                  read data channel (RRESP always OKAY)
//   reg_out                   flattened registers, reg i at [32*i+31:32*i]
//   reg_wr_pulse              one-cycle pulse, bit i set when reg i updates
//
// Configuration macro:
//   SERIAL_AXIL_WSTRB_EN  when defined, WSTRB selects which byte lanes of
//                         the target register are updated; when undefined,
//                         WSTRB is ignored and every write replaces the
//                         full word.

module serial_axil_regs #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int NUM_REGS           = 4
) (
  input  logic                               S_AXI_ACLK,
  input  logic                               S_AXI_ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_AWADDR,
  input  logic [2:0]                         S_AXI_AWPROT,
  input  logic                               S_AXI_AWVALID,
  output logic                               S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
  input  logic                               S_AXI_WVALID,
  output logic                               S_AXI_WREADY,
  output logic [1:0]                         S_AXI_BRESP,
  output logic                               S_AXI_BVALID,
  input  logic                               S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]      S_AXI_ARADDR,
  input  logic [2:0]                         S_AXI_ARPROT,
  input  logic                               S_AXI_ARVALID,
  output logic                               S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]      S_AXI_RDATA,
  output logic [1:0]                         S_AXI_RRESP,
  output logic                               S_AXI_RVALID,
  input  logic                               S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH*NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0]                reg_wr_pulse
);

  localparam int IDX_W  = C_S_AXI_ADDR_WIDTH - 2;
  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;

  typedef enum logic [1:0] {
    W_IDLE,
    W_COMMIT,
    W_RESP
  } w_state_t;

  typedef enum logic {
    R_IDLE,
    R_DATA
  } r_state_t;

  w_state_t w_state;
  r_state_t r_state;

  logic [C_S_AXI_DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                          aw_latched;
  logic                          w_latched;
  logic [IDX_W-1:0]              aw_idx;
  logic [C_S_AXI_DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]             wstrb_q;

  logic [IDX_W-1:0]              ar_idx;
  logic [NUM_REGS-1:0]           pulse_one;

  // The register index is the word address; the byte offset bits are
  // dropped, and because NUM_REGS is a power of two the index wraps.
  assign ar_idx    = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
  assign pulse_one = {{(NUM_REGS-1){1'b0}}, 1'b1};

  assign S_AXI_BRESP = 2'b00;
  assign S_AXI_RRESP = 2'b00;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_out
    assign reg_out[C_S_AXI_DATA_WIDTH*i +: C_S_AXI_DATA_WIDTH] = regs[i];
  end

  // Write channel FSM. AW and W are latched independently; each latched
  // beat drops its own ready until the response handshake completes. Once
  // both are held, one idle cycle moves to W_COMMIT, which writes the
  // register so BVALID and reg_out both change two edges after a
  // same-cycle AW+W handshake. A reset at any point discards latched beats
  // before the commit can happen.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      w_state       <= W_IDLE;
      S_AXI_AWREADY <= 1'b0;
      S_AXI_WREADY  <= 1'b0;
      S_AXI_BVALID  <= 1'b0;
      aw_latched    <= 1'b0;
      w_latched     <= 1'b0;
      aw_idx        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      reg_wr_pulse  <= '0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      reg_wr_pulse <= '0;
      case (w_state)
        W_IDLE: begin
          if (S_AXI_AWVALID && S_AXI_AWREADY) begin
            aw_idx        <= S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
            aw_latched    <= 1'b1;
            S_AXI_AWREADY <= 1'b0;
          end else begin
            S_AXI_AWREADY <= !aw_latched;
          end

          if (S_AXI_WVALID && S_AXI_WREADY) begin
            wdata_q      <= S_AXI_WDATA;
            wstrb_q      <= S_AXI_WSTRB;
            w_latched    <= 1'b1;
            S_AXI_WREADY <= 1'b0;
          end else begin
            S_AXI_WREADY <= !w_latched;
          end

          if (aw_latched && w_latched) begin
            w_state <= W_COMMIT;
          end
        end

        W_COMMIT: begin
`ifdef SERIAL_AXIL_WSTRB_EN
          for (int k = 0; k < STRB_W; k++) begin
            if (wstrb_q[k]) begin
              regs[aw_idx][8*k +: 8] <= wdata_q[8*k +: 8];
            end
          end
`else
          regs[aw_idx] <= wdata_q;
`endif
          // The pulse fires even for an all-zero strobe so the core still
          // sees that a write to this register was issued.
          reg_wr_pulse <= pulse_one << aw_idx;
          S_AXI_BVALID <= 1'b1;
          w_state      <= W_RESP;
        end

        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID  <= 1'b0;
            aw_latched    <= 1'b0;
            w_latched     <= 1'b0;
            S_AXI_AWREADY <= 1'b1;
            S_AXI_WREADY  <= 1'b1;
            w_state       <= W_IDLE;
          end
        end

        default: begin
          w_state <= W_IDLE;
        end
      endcase
    end
  end

  // Read channel FSM. RDATA is captured from the register array with a
  // non-blocking read, so a capture on the same edge as a commit to the
  // same register returns the pre-write value. RDATA is only loaded on the
  // AR handshake, which keeps it stable while RVALID waits for RREADY.
  always_ff @(posedge S_AXI_ACLK) begin
    if (S_AXI_ARESET) begin
      r_state       <= R_IDLE;
      S_AXI_ARREADY <= 1'b0;
      S_AXI_RVALID  <= 1'b0;
      S_AXI_RDATA   <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (S_AXI_ARVALID && S_AXI_ARREADY) begin
            S_AXI_RDATA   <= regs[ar_idx];
            S_AXI_RVALID  <= 1'b1;
            S_AXI_ARREADY <= 1'b0;
            r_state       <= R_DATA;
          end else begin
            S_AXI_ARREADY <= 1'b1;
          end
        end

        R_DATA: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID  <= 1'b0;
            S_AXI_ARREADY <= 1'b1;
            r_state       <= R_IDLE;
          end
        end

        default: begin
          r_state <= R_IDLE;
        end
      endcase
    end
  end

  // Protection bits and byte offsets carry no meaning for this bank.
  logic unused_inputs;
`ifdef SERIAL_AXIL_WSTRB_EN
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
`else
  logic unused_strb;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT,
                           S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};
  assign unused_strb   = ^{wstrb_q};
`endif

endmodule

// File: tb/tb_serial_axil_regs.sv
// tb_serial_axil_regs
// -------------------
// Directed, self-checking bench for serial_axil_regs. Expected register
// contents come from a small model; expected read data is pushed to a
// queue when each read address is driven and popped when RVALID appears.
// Honours SERIAL_AXIL_WSTRB_EN in its model the same way the design does.

module tb_serial_axil_regs;

  logic         clk;
  logic         reset;
  logic [3:0]   awaddr;
  logic [2:0]   awprot;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic [3:0]   wstrb;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [3:0]   araddr;
  logic [2:0]   arprot;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [127:0] reg_out;
  logic [3:0]   reg_wr_pulse;

  int assert_count = 0;
  int fail_count   = 0;

  logic [31:0] model_regs [4];
  logic [31:0] exp_q [$];

  serial_axil_regs dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESET  (reset),
    .S_AXI_AWADDR  (awaddr),
    .S_AXI_AWPROT  (awprot),
    .S_AXI_AWVALID (awvalid),
    .S_AXI_AWREADY (awready),
    .S_AXI_WDATA   (wdata),
    .S_AXI_WSTRB   (wstrb),
    .S_AXI_WVALID  (wvalid),
    .S_AXI_WREADY  (wready),
    .S_AXI_BRESP   (bresp),
    .S_AXI_BVALID  (bvalid),
    .S_AXI_BREADY  (bready),
    .S_AXI_ARADDR  (araddr),
    .S_AXI_ARPROT  (arprot),
    .S_AXI_ARVALID (arvalid),
    .S_AXI_ARREADY (arready),
    .S_AXI_RDATA   (rdata),
    .S_AXI_RRESP   (rresp),
    .S_AXI_RVALID  (rvalid),
    .S_AXI_RREADY  (rready),
    .reg_out       (reg_out),
    .reg_wr_pulse  (reg_wr_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
    assert_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_write(input int idx, input logic [31:0] d,
                                      input logic [3:0] s);
    logic [3:0] eff_s;
`ifdef SERIAL_AXIL_WSTRB_EN
    eff_s = s;
`else
    eff_s = 4'hF;
`endif
    for (int k = 0; k < 4; k++) begin
      if (eff_s[k]) model_regs[idx][8*k +: 8] = d[8*k +: 8];
    end
  endfunction

  function automatic logic [127:0] model_flat();
    logic [127:0] f;
    for (int i = 0; i < 4; i++) f[32*i +: 32] = model_regs[i];
    return f;
  endfunction

  // Full write with AW and W in the same cycle; BREADY is held low for
  // 'hold' cycles while a stray AW is offered to prove it is refused.
  task automatic axi_write(input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int hold);
    int         cyc;
    int         idx;
    logic       aw_hs;
    logic       w_hs;
    logic       stable;
    logic [3:0] exp_pulse;
    idx       = int'(addr[3:2]);
    exp_pulse = 4'b0001 << idx;
    awaddr = addr; awvalid = 1'b1;
    wdata  = data; wstrb = strb; wvalid = 1'b1;
    cyc = 0;
    while ((awvalid || wvalid) && cyc < 20) begin
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      tick();
      cyc++;
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid  = 1'b0;
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    check("wr_accept_cycles", cyc, 1);
    model_write(idx, data, strb);
    cyc = 0;
    while (!bvalid && cyc < 20) begin
      tick();
      cyc++;
    end
    check("wr_bvalid_latency", cyc, 2);
    check("wr_bresp", bresp, 2'b00);
    check("wr_pulse", reg_wr_pulse, exp_pulse);
    check("wr_reg_out", reg_out, model_flat());
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      awaddr = 4'h4; awvalid = 1'b1;
      tick();
      if (!bvalid || awready || reg_wr_pulse !== 4'b0) stable = 1'b0;
    end
    awvalid = 1'b0;
    if (hold > 0) check("wr_backpressure_stable", stable, 1'b1);
    bready = 1'b1;
    tick();
    bready = 1'b0;
    check("wr_bvalid_clear", {bvalid, reg_wr_pulse}, 5'b0);
    check("wr_ready_back", {awready, wready}, 2'b11);
  endtask

  // Full read; RREADY is held low for 'hold' cycles while a stray AR is
  // offered, and RDATA must not move during that time.
  task automatic axi_read(input logic [3:0] addr, input int hold);
    int          cyc;
    logic        hs;
    logic        stable;
    logic [31:0] held;
    logic [31:0] exp;
    araddr = addr; arvalid = 1'b1;
    exp_q.push_back(model_regs[addr[3:2]]);
    cyc = 0;
    hs  = 1'b0;
    while (!hs && cyc < 20) begin
      hs = arready;
      tick();
      cyc++;
    end
    arvalid = 1'b0;
    check("rd_accept_cycles", cyc, 1);
    check("rd_rvalid", rvalid, 1'b1);
    held   = rdata;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      araddr = 4'h0; arvalid = 1'b1;
      tick();
      if (!rvalid || arready || rdata !== held) stable = 1'b0;
    end
    arvalid = 1'b0;
    if (hold > 0) check("rd_backpressure_stable", stable, 1'b1);
    exp = exp_q.pop_front();
    check("rd_data", rdata, exp);
    check("rd_rresp", rresp, 2'b00);
    rready = 1'b1;
    tick();
    rready = 1'b0;
    check("rd_rvalid_clear", rvalid, 1'b0);
    check("rd_arready_back", arready, 1'b1);
  endtask

  initial begin
    logic bad;
    logic [31:0] exp_wstrb;

    reset = 1'b1;
    awaddr = '0; awprot = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
    araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
    for (int i = 0; i < 4; i++) model_regs[i] = '0;

    // Reset held for 20 cycles
    bad = 1'b0;
    repeat (20) begin
      tick();
      if (awready || wready || arready || bvalid || rvalid) bad = 1'b1;
    end
    check("reset_outputs_low", bad, 1'b0);
    check("reset_reg_out", reg_out, 128'h0);
    check("reset_rdata", rdata, 32'h0);
    check("reset_pulse", reg_wr_pulse, 4'h0);
    reset = 1'b0;
    check("ready_before_first_edge", {awready, wready, arready}, 3'b000);
    tick();
    check("ready_after_release", {awready, wready, arready}, 3'b111);

    // Reset between latch and commit: nothing is written
    awaddr = 4'hC; awvalid = 1'b1; wdata = 32'h5555_5555; wstrb = 4'hF;
    wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    check("midreset_latched", {awready, wready}, 2'b00);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bad = 1'b0;
    repeat (4) begin
      tick();
      if (bvalid || reg_wr_pulse !== 4'h0) bad = 1'b1;
    end
    check("midreset_no_commit", bad, 1'b0);
    check("midreset_reg_out", reg_out, 128'h0);
    check("midreset_ready", {awready, wready, arready}, 3'b111);

    // Sequential writes then reads
    for (int i = 0; i < 4; i++) axi_write(4'(i * 4), 32'(i + 1), 4'hF, 0);
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 0);

    // W three cycles ahead of AW
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    check("ord_wready_drop", {wready, awready}, 2'b01);
    tick();
    tick();
    check("ord_no_bvalid", bvalid, 1'b0);
    awaddr = 4'h8; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    model_write(2, 32'hDEAD_BEEF, 4'hF);
    tick();
    check("ord_bvalid_a1", bvalid, 1'b0);
    tick();
    check("ord_bvalid_a2", bvalid, 1'b1);
    check("ord_pulse", reg_wr_pulse, 4'b0100);
    check("ord_reg2", reg_out[95:64], 32'hDEAD_BEEF);
    bready = 1'b1;
    tick();
    bready = 1'b0;

    // Backpressure on both response channels
    axi_write(4'h0, 32'hCAFE_F00D, 4'hF, 10);
    axi_read(4'h0, 10);

    // Byte offset bits ignored
    axi_write(4'hB, 32'h0BAD_F00D, 4'hF, 0);
    axi_read(4'h9, 0);
    check("offset_reg2", reg_out[95:64], 32'h0BAD_F00D);

    // Read capture on the commit edge returns the old value
    axi_write(4'h4, 32'h11, 4'hF, 0);
    awaddr = 4'h4; awvalid = 1'b1; wdata = 32'h22; wstrb = 4'hF;
    wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    tick();
    araddr = 4'h4; arvalid = 1'b1;
    exp_q.push_back(model_regs[1]);
    tick();
    arvalid = 1'b0;
    model_write(1, 32'h22, 4'hF);
    check("col_bvalid", bvalid, 1'b1);
    check("col_rvalid", rvalid, 1'b1);
    check("col_rdata_old", rdata, exp_q.pop_front());
    check("col_reg_out", reg_out, model_flat());
    bready = 1'b1; rready = 1'b1;
    tick();
    bready = 1'b0; rready = 1'b0;
    axi_read(4'h4, 0);

    // Byte strobes
`ifdef SERIAL_AXIL_WSTRB_EN
    exp_wstrb = 32'hAA22_CC44;
`else
    exp_wstrb = 32'h1122_3344;
`endif
    axi_write(4'h0, 32'hAABB_CCDD, 4'hF, 0);
    axi_write(4'h0, 32'h1122_3344, 4'b0101, 0);
    check("wstrb_reg0", reg_out[31:0], exp_wstrb);
    axi_write(4'h0, 32'hFFFF_FFFF, 4'b0000, 0);
`ifdef SERIAL_AXIL_WSTRB_EN
    check("wstrb_zero_reg0", reg_out[31:0], exp_wstrb);
`else
    check("wstrb_zero_reg0", reg_out[31:0], 32'hFFFF_FFFF);
`endif
    axi_read(4'h0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             assert_count, fail_count);
    $finish;
  end

endmodule
